// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// register-index width and execute-operand forward selects.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [1:0]       fwd_t;

    localparam fwd_t FWD_RF = 2'b00;
    localparam fwd_t FWD_M  = 2'b01;
    localparam fwd_t FWD_W  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-source select for one execute-stage operand; the youngest
// producer (M) wins over W, and x0 never forwards.
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] e_rs,
    input  logic [REG_W-1:0] m_rd,
    input  logic             m_we,
    input  logic             m_load,
    input  logic [REG_W-1:0] w_rd,
    input  logic             w_we,
    output logic [1:0]       sel
);

    logic m_hit;
    logic w_hit;

    // A load in M has no data yet; load-use stalling keeps that case away.
    assign m_hit = m_we && !m_load && (m_rd != '0) && (m_rd == e_rs);
    assign w_hit = w_we && (w_rd != '0) && (w_rd == e_rs);

    always_comb begin
        sel = FWD_RF;
        if (m_hit) begin
            sel = FWD_M;
        end else if (w_hit) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: tracks E/M/W destination
// shadows, detects load-use stalls and redirects, and selects forwards.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             rs1_used_d,
    input  logic             rs2_used_d,
    input  logic [REG_W-1:0] rd_d,
    input  logic             we_d,
    input  logic             load_d,
    input  logic             jb,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             bubble_e,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [31:0]      stall_cnt
);

    logic [REG_W-1:0] e_rs1, e_rs2, e_rd;
    logic             e_we, e_load;
    logic [REG_W-1:0] m_rd;
    logic             m_we, m_load;
    logic [REG_W-1:0] w_rd;
    logic             w_we;

    logic rs1_haz, rs2_haz, lu;

    assign rs1_haz = rs1_used_d && (rs1_d != '0) && (rs1_d == e_rd);
    assign rs2_haz = rs2_used_d && (rs2_d != '0) && (rs2_d == e_rd);
    assign lu      = e_load && e_we && (e_rd != '0) && (rs1_haz || rs2_haz);

    // A redirect squashes the dependent instruction, so it overrides the stall.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        bubble_e = 1'b0;
        if (jb) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
        end else if (lu) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
        end
    end

    // D -> E boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_rs1  <= '0;
            e_rs2  <= '0;
            e_rd   <= '0;
            e_we   <= 1'b0;
            e_load <= 1'b0;
        end else if (bubble_e) begin
            e_rs1  <= '0;
            e_rs2  <= '0;
            e_rd   <= '0;
            e_we   <= 1'b0;
            e_load <= 1'b0;
        end else begin
            e_rs1  <= rs1_d;
            e_rs2  <= rs2_d;
            e_rd   <= rd_d;
            e_we   <= we_d;
            e_load <= load_d;
        end
    end

    // E -> M -> W boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rd   <= '0;
            m_we   <= 1'b0;
            m_load <= 1'b0;
            w_rd   <= '0;
            w_we   <= 1'b0;
        end else begin
            m_rd   <= e_rd;
            m_we   <= e_we;
            m_load <= e_load;
            w_rd   <= m_rd;
            w_we   <= m_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (lu && !jb) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    fwd_sel u_fwd_a (
        .e_rs   (e_rs1),
        .m_rd   (m_rd),
        .m_we   (m_we),
        .m_load (m_load),
        .w_rd   (w_rd),
        .w_we   (w_we),
        .sel    (fwd_a)
    );

    fwd_sel u_fwd_b (
        .e_rs   (e_rs2),
        .m_rd   (m_rd),
        .m_we   (m_we),
        .m_load (m_load),
        .w_rd   (w_rd),
        .w_we   (w_we),
        .sel    (fwd_b)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding priority, x0,
// redirect-vs-stall, asynchronous reset and stall counter wrap.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        rs1_used_d, rs2_used_d, we_d, load_d, jb;
    logic        stall_f, stall_d, flush_d, bubble_e;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rs1_used_d (rs1_used_d),
        .rs2_used_d (rs2_used_d),
        .rd_d       (rd_d),
        .we_d       (we_d),
        .load_d     (load_d),
        .jb         (jb),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .bubble_e   (bubble_e),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_cnt  (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        rs1_d = r1; rs1_used_d = u1;
        rs2_d = r2; rs2_used_d = u2;
        rd_d = rd; we_d = we; load_d = ld;
    endtask

    task automatic nop_d();
        set_d(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input string tag, input logic sf, input logic sd,
                       input logic fd, input logic be);
        check_eq({tag, "_ctl"}, {28'd0, stall_f, stall_d, flush_d, bubble_e},
                 {28'd0, sf, sd, fd, be});
    endtask

    // A load still in M feeding an E source must never occur.
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(dut.m_load && dut.m_we && dut.m_rd != 5'd0 &&
                      (dut.m_rd == dut.e_rs1 || dut.m_rd == dut.e_rs2)))
            else begin
                n_fail++;
                $display("FAIL m_load_feeds_e: m_rd=%0d e_rs1=%0d e_rs2=%0d",
                         dut.m_rd, dut.e_rs1, dut.e_rs2);
            end
        end
    end

    initial begin
        rst = 1'b1;
        jb  = 1'b0;
        nop_d();
        #2;
        ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_cnt", stall_cnt, 32'd0);
        check_eq("reset_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        jb = 1'b1;
        #1;
        ctl("reset_jb", 1'b0, 1'b0, 1'b1, 1'b1);
        jb = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // load-use on x5
        set_d(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_d(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        ctl("lu", 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("lu_cnt0", stall_cnt, 32'd0);
        tick();
        check_eq("lu_cnt1", stall_cnt, 32'd1);
        ctl("lu_release", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("lu_e_zero", {22'd0, dut.e_rd, dut.e_rs1, dut.e_we, dut.e_load}, 32'd0);
        tick();
        check_eq("lu_fwd_w", {30'd0, fwd_a}, 32'd2);
        check_eq("lu_cnt_hold", stall_cnt, 32'd1);
        nop_d();

        // forward priority: x7 in M and W
        set_d(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        tick();
        set_d(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        check_eq("fwd_m_a", {30'd0, fwd_a}, 32'd1);
        check_eq("fwd_m_b", {30'd0, fwd_b}, 32'd1);
        ctl("fwd_m", 1'b0, 1'b0, 1'b0, 1'b0);
        // x7 only in W after M retires
        set_d(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        nop_d();
        tick();
        set_d(5'd3, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        check_eq("fwd_w_a", {30'd0, fwd_a}, 32'd0);
        check_eq("fwd_w_b", {30'd0, fwd_b}, 32'd2);
        nop_d();

        // x0: load to x0, reader of x0
        set_d(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_d(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        ctl("x0", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("x0_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        check_eq("x0_cnt", stall_cnt, 32'd1);
        nop_d();

        // redirect together with load-use on x9
        set_d(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        set_d(5'd0, 1'b0, 5'd9, 1'b1, 5'd2, 1'b1, 1'b0);
        jb = 1'b1;
        #1;
        ctl("jb_lu", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        jb = 1'b0;
        nop_d();
        #1;
        check_eq("jb_cnt", stall_cnt, 32'd1);
        check_eq("jb_e_zero", {26'd0, dut.e_rd, dut.e_load}, 32'd0);

        // asynchronous reset during a stall on x4
        set_d(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        set_d(5'd4, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        #1;
        ctl("rst_pre", 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        ctl("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_async_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        ctl("rst_post", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ctl("rst_post2", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_post_cnt", stall_cnt, 32'd0);
        nop_d();

        // stall counter wrap
        set_d(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
        tick();
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        set_d(5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        #1;
        ctl("wrap_lu", 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
        tick();
        check_eq("wrap_cnt", stall_cnt, 32'd0);
        nop_d();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
